ro_count_uart_tx: RTL
=====================

# ro_count_uart_tx

Serializes each 16-bit ring-oscillator count onto the `tx` pin as a fixed 4-byte UART frame: sync, count MSB, count LSB, checksum. It is the transmit end of the host link whose receive side is decoded by the host-side UART. It sits between the measurement counter, which supplies the data through a valid/ready handshake, and `uo_out[0]`.

## Interface
- `CLKS_PER_BIT`, default 87 — clock cycles per UART bit (10 MHz / 115200); legal range ≥ 2.
- `SYNC_BYTE`, default 8'hA5 — first byte of every frame.
- `clk`  in  1  — system clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `meas_data`  in  16  — count to send; sampled only on handshake.
- `meas_valid`  in  1  — producer has a count.
- `meas_ready`  out  1  — block accepts a count; high only in IDLE.
- `tx`  out  1  — UART line, idle high.
- `busy`  out  1  — frame in progress; equals `~meas_ready`.

## Operation
- Reset values: `tx`=1, `meas_ready`=1, `busy`=0, state IDLE, byte index 0, bit and baud counters 0.
- Handshake: transfer occurs on a cycle where `meas_valid && meas_ready`. `meas_data` is latched on that cycle. `meas_valid` while busy is ignored: no queueing, no error.
- Frame bytes, in order: `SYNC_BYTE`, `meas_data[15:8]`, `meas_data[7:0]`, and `chk = SYNC_BYTE ^ hi ^ lo`. The checksum is computed from the latched copy.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). 10 bits per byte.
- State machine: IDLE → START → DATA → STOP.
  - IDLE → START on handshake.
  - START → DATA after one bit time.
  - DATA → STOP after 8 bit times.
  - STOP → START if byte index < 3 (index increments), else STOP → IDLE.
- No gap between bytes: the next start bit begins on the cycle after the previous stop bit ends.
- Baud counter runs 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. Its width is `$clog2(CLKS_PER_BIT)`. Bit counter is 3 bits; byte index is 2 bits.
- `rst` mid-frame takes effect on the next edge: frame aborted, latched data discarded, all outputs return to reset values. No partial byte is completed.
- Handshake and reset on the same cycle: reset wins, and nothing is accepted.

## Timing
- Handshake at edge N → `tx`=0 (start bit of the sync byte) from edge N+1.
- Every bit holds for exactly `CLKS_PER_BIT` cycles.
- Frame length is exactly 40 × `CLKS_PER_BIT` cycles from edge N+1.
- `meas_ready` reasserts on the cycle the last stop bit ends. A new handshake is allowed on that same cycle, giving a back-to-back frame with no idle bit.
- `tx` is driven directly from a flop, so it is glitch-free.
- Maximum throughput is one count per 40 × `CLKS_PER_BIT` cycles.

## Structure
- Shared package `ro_uart_pkg` holds:
  - state enum {IDLE, START, DATA, STOP};
  - `FRAME_BYTES` = 4;
  - default `SYNC_BYTE`;
  - `BITS_PER_BYTE` = 8.
- One natural sub-module, `uart_tx_byte`, handles per-byte serialization and baud timing:
  - inputs: byte, start strobe;
  - outputs: `tx`, `done` pulse.
- The top level sequences the 4 bytes, computes the checksum, and handles the handshake.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, which gives a 160-cycle frame.
- Reset: hold `rst` for 2 cycles → `tx`=1, `meas_ready`=1, `busy`=0, and they stay so with `meas_valid`=0 for 100 cycles.
- Single frame: send 0x1234 → bytes A5, 12, 34, 83 decoded LSB-first with correct start/stop bits. `tx` low at N+1; `meas_ready` high again at N+161.
- Back-to-back: hold `meas_valid` high with 0xFFFF, then 0x0000 → two contiguous frames (A5 FF FF A5, A5 00 00 A5). No idle-high bit between the frames; second handshake exactly 160 cycles after the first.
- Busy ignore: pulse `meas_valid` with 0xBEEF at cycle 50 of a 0x1234 frame → only the 0x1234 frame is sent, then `tx` stays idle.
- Reset mid-frame: assert `rst` at cycle 60 (inside the MSB byte) → `tx`=1 and `meas_ready`=1 on the next edge. A following 0x0001 frame sends A5 00 01 A4 cleanly.
- Bit timing: sample `tx` every cycle during one frame → every bit level is constant for exactly 4 cycles, with transitions only at multiples of 4 from N+1.

Source files
------------

// File: rtl/ro_uart_pkg.sv
// Shared types and constants for the ring-oscillator count UART link.
package ro_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam int          FRAME_BYTES       = 4;
    localparam int          BITS_PER_BYTE     = 8;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] frame_chk(input logic [7:0] sync,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
        return sync ^ hi ^ lo;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serializes one byte as start/8 data (LSB first)/stop with a registered tx line.
// A start strobe during the last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
    import ro_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_e      state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           baud_end;

    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign done     = (state_q == STOP) && baud_end;
    assign tx       = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    baud_d  = '0;
                    shreg_d = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        // next bit is presented before the shift lands
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (start) begin
                        state_d = START;
                        shreg_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/ro_count_uart_tx.sv
// Sends each accepted 16-bit count as a 4-byte UART frame: sync, MSB, LSB, checksum.
// Ready reasserts in the last stop-bit cycle so a new count can follow with no idle bit.
module ro_count_uart_tx
    import ro_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 87,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] meas_data,
    input  logic        meas_valid,
    output logic        meas_ready,
    output logic        tx,
    output logic        busy
);

    logic        active_q;
    logic [1:0]  idx_q;
    logic [15:0] data_q;
    logic        byte_done;
    logic        last_byte;
    logic        handshake;
    logic        byte_start;
    logic [7:0]  next_byte;
    logic [7:0]  byte_data;

    assign last_byte  = (idx_q == 2'(FRAME_BYTES - 1));
    assign meas_ready = !active_q || (byte_done && last_byte);
    assign busy       = ~meas_ready;
    assign handshake  = meas_valid && meas_ready && !rst;
    assign byte_start = handshake || (byte_done && !last_byte);
    assign byte_data  = handshake ? SYNC_BYTE : next_byte;

    always_comb begin
        next_byte = SYNC_BYTE;
        case (idx_q)
            2'd0:    next_byte = data_q[15:8];
            2'd1:    next_byte = data_q[7:0];
            2'd2:    next_byte = frame_chk(SYNC_BYTE, data_q[15:8], data_q[7:0]);
            default: next_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
        end else if (handshake) begin
            active_q <= 1'b1;
            idx_q    <= '0;
            data_q   <= meas_data;
        end else if (byte_done) begin
            if (last_byte) begin
                active_q <= 1'b0;
                idx_q    <= '0;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .done  (byte_done)
    );

endmodule
